// File: rtl/boot_load_ctrl.sv
// Boot loader: receives a length-prefixed little-endian word stream over UART, writes it to port B, then hands port B to the CPU.
// Optional feature macro: BOOT_CHECKSUM_EN (adds a trailing XOR checksum byte check).
module boot_load_ctrl #(
  parameter logic [31:0] BASE_ADDR      = 32'h0000_0000,
  parameter int unsigned MAX_WORDS      = 16384,
  parameter int unsigned TIMEOUT_CYCLES = 1_000_000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [7:0]  rx_data,
  input  logic        rx_valid,
  input  logic        boot_req,
  input  logic [31:0] cpu_addr,
  input  logic [31:0] cpu_wdata,
  input  logic        cpu_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic        mem_we,
  output logic        cpu_hold,
  output logic        uart_done,
  output logic        load_err,
  output logic [31:0] words_loaded
);

  localparam int unsigned      CNT_W    = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
  localparam logic [31:0]      MAX_N    = 32'(MAX_WORDS);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LEN,
    S_DATA,
`ifdef BOOT_CHECKSUM_EN
    S_CHK,
`endif
    S_DONE,
    S_ERR
  } state_t;

`ifdef BOOT_CHECKSUM_EN
  localparam state_t S_FIN = S_CHK;
`else
  localparam state_t S_FIN = S_DONE;
`endif

  state_t           state_q, state_d;
  logic [1:0]       idx_q, idx_d;
  logic [23:0]      word_q, word_d;
  logic [31:0]      len_q, len_d;
  logic [31:0]      words_q, words_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             started_q, started_d;
  logic             wr_en_q, wr_en_d;
  logic [31:0]      wr_addr_q, wr_addr_d;
  logic [31:0]      wr_data_q, wr_data_d;
  logic             hold_q, done_q, err_q;
  logic [31:0]      assembled;
`ifdef BOOT_CHECKSUM_EN
  logic [7:0]       csum_q, csum_d;
`endif

  assign assembled = {rx_data, word_q};

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q   <= S_IDLE;
      idx_q     <= 2'd0;
      word_q    <= 24'd0;
      len_q     <= 32'd0;
      words_q   <= 32'd0;
      cnt_q     <= '0;
      started_q <= 1'b0;
      wr_en_q   <= 1'b0;
      wr_addr_q <= 32'd0;
      wr_data_q <= 32'd0;
      hold_q    <= 1'b1;
      done_q    <= 1'b0;
      err_q     <= 1'b0;
`ifdef BOOT_CHECKSUM_EN
      csum_q    <= 8'd0;
`endif
    end else begin
      state_q   <= state_d;
      idx_q     <= idx_d;
      word_q    <= word_d;
      len_q     <= len_d;
      words_q   <= words_d;
      cnt_q     <= cnt_d;
      started_q <= started_d;
      wr_en_q   <= wr_en_d;
      wr_addr_q <= wr_addr_d;
      wr_data_q <= wr_data_d;
      hold_q    <= (state_d != S_DONE);
      done_q    <= (state_d == S_DONE);
      err_q     <= (state_d == S_ERR);
`ifdef BOOT_CHECKSUM_EN
      csum_q    <= csum_d;
`endif
    end
  end

  // Next-state and loader datapath
  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    word_d    = word_q;
    len_d     = len_q;
    words_d   = words_q;
    cnt_d     = cnt_q;
    started_d = started_q;
    wr_en_d   = 1'b0;
    wr_addr_d = wr_addr_q;
    wr_data_d = wr_data_q;
`ifdef BOOT_CHECKSUM_EN
    csum_d    = csum_q;
`endif
    case (state_q)
      S_IDLE: state_d = S_LEN;
      S_LEN, S_DATA: begin
`ifndef BOOT_CHECKSUM_EN
        // Last write is in flight this cycle; release the CPU on the next one
        if (state_q == S_DATA && words_q == len_q) begin
          state_d = S_DONE;
        end else
`endif
        if (rx_valid) begin
          cnt_d     = '0;
          started_d = 1'b1;
          idx_d     = idx_q + 2'd1;
          word_d    = {rx_data, word_q[23:8]};
`ifdef BOOT_CHECKSUM_EN
          csum_d    = csum_q ^ rx_data;
`endif
          if (idx_q == 2'd3) begin
            if (state_q == S_LEN) begin
              len_d = assembled;
              if (assembled == 32'd0)    state_d = S_FIN;
              else if (assembled > MAX_N) state_d = S_ERR;
              else                        state_d = S_DATA;
            end else begin
              wr_en_d   = 1'b1;
              wr_addr_d = BASE_ADDR + {words_q[29:0], 2'b00};
              wr_data_d = assembled;
              words_d   = words_q + 32'd1;
`ifdef BOOT_CHECKSUM_EN
              if (words_q + 32'd1 == len_q) state_d = S_CHK;
`endif
            end
          end
        end else if (started_q) begin
          if (cnt_q == CNT_LAST) state_d = S_ERR;
          else                   cnt_d   = cnt_q + CNT_W'(1);
        end
      end
`ifdef BOOT_CHECKSUM_EN
      S_CHK: begin
        if (rx_valid) state_d = (rx_data == csum_q) ? S_DONE : S_ERR;
      end
`endif
      S_DONE, S_ERR: begin
        if (boot_req) begin
          state_d   = S_LEN;
          idx_d     = 2'd0;
          word_d    = 24'd0;
          words_d   = 32'd0;
          cnt_d     = '0;
          started_d = 1'b0;
`ifdef BOOT_CHECKSUM_EN
          csum_d    = 8'd0;
`endif
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Port B owner: CPU only once loading is done
  always_comb begin
    if (state_q == S_DONE) begin
      mem_addr  = cpu_addr;
      mem_wdata = cpu_wdata;
      mem_we    = cpu_we;
    end else begin
      mem_addr  = wr_addr_q;
      mem_wdata = wr_data_q;
      mem_we    = wr_en_q;
    end
  end

  assign cpu_hold     = hold_q;
  assign uart_done    = done_q;
  assign load_err     = err_q;
  assign words_loaded = words_q;

endmodule

// File: tb/tb_boot_load_ctrl.sv
// Directed bench for boot_load_ctrl with a short timeout; checksum cases run when BOOT_CHECKSUM_EN is defined.
module tb_boot_load_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic [7:0]  rx_data;
  logic        rx_valid;
  logic        boot_req;
  logic [31:0] cpu_addr;
  logic [31:0] cpu_wdata;
  logic        cpu_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic        mem_we;
  logic        cpu_hold;
  logic        uart_done;
  logic        load_err;
  logic [31:0] words_loaded;

  int total = 0;
  int bad   = 0;
  logic [7:0]  xr;
  logic [31:0] wq_addr[$];
  logic [31:0] wq_data[$];
  logic [7:0]  dbytes[12];
  logic [31:0] exp_data[3];

  always #5 clk = ~clk;

  boot_load_ctrl #(
    .BASE_ADDR(32'h0000_0000),
    .MAX_WORDS(16384),
    .TIMEOUT_CYCLES(100)
  ) dut (
    .clk(clk), .rst(rst), .rx_data(rx_data), .rx_valid(rx_valid), .boot_req(boot_req),
    .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata), .cpu_we(cpu_we),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_we(mem_we),
    .cpu_hold(cpu_hold), .uart_done(uart_done), .load_err(load_err),
    .words_loaded(words_loaded)
  );

  // Loader-owned port B writes
  always @(negedge clk) begin
    if (mem_we && cpu_hold) begin
      wq_addr.push_back(mem_addr);
      wq_data.push_back(mem_wdata);
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] b);
    rx_data  = b;
    rx_valid = 1'b1;
    xr       = xr ^ b;
    @(posedge clk);
    #1;
    rx_valid = 1'b0;
  endtask

  task automatic pulse_boot();
    boot_req = 1'b1;
    step(1);
    boot_req = 1'b0;
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, "_hold"},  32'(cpu_hold),  32'd1);
    check({tag, "_done"},  32'(uart_done), 32'd0);
    check({tag, "_err"},   32'(load_err),  32'd0);
    check({tag, "_we"},    32'(mem_we),    32'd0);
    check({tag, "_addr"},  mem_addr,       32'd0);
    check({tag, "_wdata"}, mem_wdata,      32'd0);
    check({tag, "_words"}, words_loaded,   32'd0);
  endtask

  initial begin
    rst = 1'b0; rx_data = 8'd0; rx_valid = 1'b0; boot_req = 1'b0;
    cpu_addr = 32'd0; cpu_wdata = 32'd0; cpu_we = 1'b0; xr = 8'd0;
    dbytes   = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66, 8'h77, 8'h88,
                 8'h99, 8'hAA, 8'hBB, 8'hCC};
    exp_data = '{32'h4433_2211, 32'h8877_6655, 32'hCCBB_AA99};
    step(3);
    check_reset_vals("rst");

    // Two-word load while the CPU tries to store
    rst = 1'b1;
    cpu_addr = 32'h100; cpu_wdata = 32'hA5; cpu_we = 1'b1;
    step(1);
    check("len_we_blocked", 32'(mem_we), 32'd0);
    xr = 8'd0;
    send_byte(8'h02); send_byte(8'h00); send_byte(8'h00); send_byte(8'h00);
    send_byte(8'h78); send_byte(8'h56); send_byte(8'h34); send_byte(8'h12);
    check("w0_we",    32'(mem_we), 32'd1);
    check("w0_addr",  mem_addr,    32'h0);
    check("w0_data",  mem_wdata,   32'h1234_5678);
    check("w0_count", words_loaded, 32'd1);
    step(1);
    check("w0_pulse", 32'(mem_we), 32'd0);
    send_byte(8'hEF); send_byte(8'hBE); send_byte(8'hAD); send_byte(8'hDE);
    check("w1_we",    32'(mem_we), 32'd1);
    check("w1_addr",  mem_addr,    32'h4);
    check("w1_data",  mem_wdata,   32'hDEAD_BEEF);
    check("w1_notdone", 32'(uart_done), 32'd0);
    check("w1_hold",  32'(cpu_hold), 32'd1);
`ifdef BOOT_CHECKSUM_EN
    send_byte(xr);
`else
    step(1);
`endif
    check("l1_done",  32'(uart_done), 32'd1);
    check("l1_hold",  32'(cpu_hold),  32'd0);
    check("l1_words", words_loaded,   32'd2);
    check("pass_addr", mem_addr,  32'h100);
    check("pass_data", mem_wdata, 32'hA5);
    check("pass_we",   32'(mem_we), 32'd1);
    cpu_addr = 32'h200;
    #1;
    check("pass_comb", mem_addr, 32'h200);
    check("l1_nwrites", 32'(wq_addr.size()), 32'd2);

    // Restart from DONE, then back-to-back 3-word load
    wq_addr.delete(); wq_data.delete();
    pulse_boot();
    check("rb_done",  32'(uart_done), 32'd0);
    check("rb_words", words_loaded,   32'd0);
    check("rb_we",    32'(mem_we),    32'd0);
    check("rb_addr",  mem_addr,       32'h4);
    xr = 8'd0;
    send_byte(8'h03); send_byte(8'h00); send_byte(8'h00); send_byte(8'h00);
    for (int i = 0; i < 12; i++) send_byte(dbytes[i]);
`ifdef BOOT_CHECKSUM_EN
    send_byte(xr);
`else
    step(1);
`endif
    check("b2b_done",   32'(uart_done), 32'd1);
    check("b2b_words",  words_loaded,   32'd3);
    check("b2b_writes", 32'(wq_addr.size()), 32'd3);
    for (int i = 0; i < 3; i++) begin
      if (i < wq_addr.size()) begin
        check($sformatf("b2b_addr%0d", i), wq_addr[i], 32'(4 * i));
        check($sformatf("b2b_data%0d", i), wq_data[i], exp_data[i]);
      end
    end

    // Largest length accepted; reset mid-DATA
    wq_addr.delete(); wq_data.delete();
    pulse_boot();
    xr = 8'd0;
    send_byte(8'h00); send_byte(8'h40); send_byte(8'h00); send_byte(8'h00);
    check("max_noerr", 32'(load_err), 32'd0);
    check("max_hold",  32'(cpu_hold), 32'd1);
    send_byte(8'h01);
    rst = 1'b0;
    step(1);
    check_reset_vals("midrst");
    rst = 1'b1;
    step(1);

    // Over-length rejected with no write
    send_byte(8'h01); send_byte(8'h40); send_byte(8'h00); send_byte(8'h00);
    check("ovr_err",  32'(load_err), 32'd1);
    check("ovr_hold", 32'(cpu_hold), 32'd1);
    send_byte(8'h01); send_byte(8'h02); send_byte(8'h03); send_byte(8'h04);
    check("ovr_stay",    32'(load_err), 32'd1);
    check("ovr_nowrite", 32'(wq_addr.size()), 32'd0);

    // Timeout mid-frame, indefinite wait before first byte
    pulse_boot();
    check("to_clr", 32'(load_err), 32'd0);
    step(150);
    check("to_wait", 32'(load_err), 32'd0);
    send_byte(8'h05); send_byte(8'h00);
    step(99);
    check("to_early", 32'(load_err), 32'd0);
    step(1);
    check("to_fire", 32'(load_err), 32'd1);
    check("to_hold", 32'(cpu_hold), 32'd1);
    pulse_boot();
    check("to_reboot", 32'(load_err), 32'd0);
    check("to_words",  words_loaded,  32'd0);

`ifdef BOOT_CHECKSUM_EN
    // Wrong checksum byte keeps the CPU held
    wq_addr.delete(); wq_data.delete();
    xr = 8'd0;
    send_byte(8'h01); send_byte(8'h00); send_byte(8'h00); send_byte(8'h00);
    send_byte(8'hAA); send_byte(8'hBB); send_byte(8'hCC); send_byte(8'hDD);
    send_byte(xr ^ 8'hFF);
    check("chk_err",    32'(load_err),  32'd1);
    check("chk_hold",   32'(cpu_hold),  32'd1);
    check("chk_writes", 32'(wq_addr.size()), 32'd1);
    pulse_boot();
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/boot_load_ctrl.md
# boot_load_ctrl

Boot-time program loader and data-port arbiter between the UART receiver, the CPU MEM stage and memory port B. After reset it holds the CPU, collects a length-prefixed word stream from the UART byte receiver, and writes each word into memory. It then releases port B and the CPU. It replaces the ad-hoc `uart_done` mux at the CPU top level with one sequenced owner of port B.

## Interface
Parameters:
- `BASE_ADDR`, default 32'h0000_0000: byte address of the first loaded word.
- `MAX_WORDS`, default 16384: largest accepted word count. A larger count is an error.
- `TIMEOUT_CYCLES`, default 1_000_000: idle cycles allowed mid-frame before the load aborts.

Ports:
- `clk`, input, 1: system clock. The block has one clock.
- `rst`, input, 1: reset, synchronous and active-low.
- `rx_data`, input, 8: received UART byte.
- `rx_valid`, input, 1: single-cycle strobe. `rx_data` is valid in that cycle.
- `boot_req`, input, 1: restarts loading from DONE or ERR. Level, sampled each cycle.
- `cpu_addr`, input, 32: MEM-stage data address.
- `cpu_wdata`, input, 32: MEM-stage store data.
- `cpu_we`, input, 1: MEM-stage write enable.
- `mem_addr`, output, 32: address driven to memory port B.
- `mem_wdata`, output, 32: write data driven to memory port B.
- `mem_we`, output, 1: write enable driven to memory port B.
- `cpu_hold`, output, 1: keeps the pipeline in reset or stall while high.
- `uart_done`, output, 1: load completed successfully; port B belongs to the CPU.
- `load_err`, output, 1: load aborted; stays high until `boot_req` or reset.
- `words_loaded`, output, 32: count of words written during the current load.

## Operation
States and transitions:
- IDLE is entered from reset. It moves to LEN unconditionally on the next cycle.
- LEN collects 4 bytes as a little-endian word count N.
  - If N == 0, go to DONE (or to CHK when checksum is enabled).
  - If N > MAX_WORDS, go to ERR.
  - Otherwise go to DATA.
- DATA collects bytes little-endian into a 32-bit word.
  - On the 4th byte, the word and the address BASE_ADDR + 4·`words_loaded` are registered and a write is issued.
  - After word N the state goes to DONE (CHK when checksum is enabled).
- DONE: `uart_done`=1 and `cpu_hold`=0. `rx_valid` is ignored. `boot_req`=1 returns the block to LEN and clears `words_loaded`.
- ERR: `load_err`=1 and `cpu_hold`=1. Only `boot_req` or reset leaves it; either returns to LEN and clears `load_err`.

Byte and write handling:
- The byte index is a 2-bit counter that wraps 3→0 on each accepted byte.
- Bytes keep being accepted in the cycle a write is issued. No byte is dropped at any rate up to one byte every cycle.

Port B mux:
- In DONE, `mem_*` outputs are a combinational pass-through of `cpu_*`.
- In every other state, `mem_*` outputs are the loader's registered signals, and `cpu_we` is ignored.

Timeout:
- The idle counter resets on every `rx_valid`.
- It counts only in LEN or DATA after the first byte of a frame has been received.
- When it reaches TIMEOUT_CYCLES, the state goes to ERR.
- Before the first byte, the block waits indefinitely.

## Timing
Reset values:
- `cpu_hold`=1.
- `uart_done`, `load_err`, `mem_we` = 0.
- `mem_addr`, `mem_wdata`, `words_loaded` = 0.
- State = IDLE, byte index = 0, idle counter = 0.

Write and completion timing:
- Write latency: 4th byte strobe in cycle t → `mem_we`=1 for exactly cycle t+1, with `mem_addr`/`mem_wdata` stable in t+1.
- `words_loaded` increments in t+1.
- Completion: the last write is in cycle t+1 → `uart_done`=1 and `cpu_hold`=0 from t+2. The final write always completes before the CPU is released.

Simultaneous events:
- Reset has priority over all inputs. Asserting reset mid-load aborts the load, and no further write is issued.
- If `boot_req` is high in DONE, the DONE→LEN transition takes effect next cycle, and port B returns to the loader in that same cycle.
- If `rx_valid` and the timeout terminal count occur in the same cycle, the byte wins and the counter is cleared.

## Configuration
- `BOOT_CHECKSUM_EN` defined:
  - After the last data word, state CHK accepts one byte.
  - Pass condition: that byte XOR the XOR of all length and data bytes equals 0 → DONE, one cycle after the byte.
  - Otherwise → ERR. Memory keeps the written words, and `cpu_hold` stays 1.
- `BOOT_CHECKSUM_EN` undefined: no CHK state. The block goes to DONE directly after the last write.

## Test plan
- Length 2 (bytes 02 00 00 00), then bytes 78 56 34 12 EF BE AD DE → writes 0x12345678 @0x0 and 0xDEADBEEF @0x4, each with a 1-cycle `mem_we`. `uart_done` rises 1 cycle after the second write. `words_loaded`=2.
- Back-to-back `rx_valid` every cycle for a 3-word load → 3 writes at 0x0/0x4/0x8, no data lost.
- Length 00 40 00 00 (16384) accepted. Length 01 40 00 00 → `load_err`=1 and no `mem_we` ever.
- 2 of 4 bytes sent, then silence for TIMEOUT_CYCLES (test param 100) → ERR at cycle 100. `boot_req` → LEN with `load_err`=0.
- After DONE, `cpu_addr`=0x100, `cpu_wdata`=0xA5, `cpu_we`=1 → `mem_*` equal the same values in the same cycle. During the load, `cpu_we`=1 never reaches `mem_we`.
- With `BOOT_CHECKSUM_EN`: 1-word load, correct XOR byte → DONE; wrong byte → ERR with `cpu_hold`=1. Reset mid-DATA → all outputs at reset values on the next edge.
